// File: rtl/crossy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crossy_pkg
// Description : Shared types and constants for the Crossy Robbers round
//               sequencer: game state encoding, winner encoding, HID key
//               codes and a binary-to-BCD helper for two-digit constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package crossy_pkg;

  typedef enum logic [2:0] {
    ST_TITLE     = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_t;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;

  // Two-digit BCD of a value in 0..99, {tens, ones}.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : frame_tick_gen
// Description : Synchronises the raw active-low VGA vsync, emits a one-cycle
//               frame_tick on every synchronised 0->1 edge (end of the sync
//               pulse) and divides frames into game seconds.
// Ports       : clk, rst_n      - clock, async active-low reset
//               vs             - raw vsync, asynchronous to clk
//               clear          - zero the frame counter (state entry)
//               run            - let the frame counter advance
//               frame_tick     - 1-cycle pulse per frame, 3 clk after pin edge
//               sec_tick       - coincides with the frame_tick that wraps
//                                the frame counter
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_gen #(
  parameter int unsigned FRAMES_PER_SEC = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  input  logic clear,
  input  logic run,
  output logic frame_tick,
  output logic sec_tick
);

  localparam int unsigned CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAMES_PER_SEC - 1);

  logic             vs_meta_q;
  logic             vs_sync_q;
  logic             vs_prev_q;
  logic             frame_tick_q;
  logic             sec_tick_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] frame_cnt_d;
  logic             sec_tick_d;
  logic             vs_rise;

  assign vs_rise = vs_sync_q & ~vs_prev_q;

  // A clear always wins: any frame landing on a state-entry edge is dropped
  // from the count so the new state starts from a clean zero.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    sec_tick_d  = 1'b0;
    if (clear) begin
      frame_cnt_d = '0;
    end else if (run && vs_rise) begin
      if (frame_cnt_q == CNT_MAX) begin
        frame_cnt_d = '0;
        sec_tick_d  = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  // Sync flops reset high (vsync idle level) so reset release never fakes
  // a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta_q    <= 1'b1;
      vs_sync_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      frame_tick_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vs_meta_q    <= vs;
      vs_sync_q    <= vs_meta_q;
      vs_prev_q    <= vs_sync_q;
      frame_tick_q <= vs_rise;
      sec_tick_q   <= sec_tick_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign sec_tick   = sec_tick_q;

endmodule
`default_nettype wire

// File: rtl/game_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : game_round_controller
// Description : Crossy Robbers game sequencer. Runs the title / countdown /
//               play / pause / game-over flow, gates player movement, keeps
//               both scores and the BCD round timer, and picks the winner.
// Ports       : Clk, Reset_n              - clock, async active-low reset
//               vs                        - raw VGA vsync (active low)
//               keycode                   - current USB HID keycode, 0 = none
//               p1_score_evt/p2_score_evt - 1-cycle loot-banked pulses
//               state                     - game_state_t encoding
//               frame_tick                - 1-cycle pulse per frame
//               player_reset/enable       - hold at spawn / allow movement
//               timer_tens/timer_ones     - BCD seconds remaining
//               countdown                 - countdown digit, 0 elsewhere
//               p1_score/p2_score         - scores
//               winner                    - 00 none, 01 P1, 10 P2, 11 tie
// Revision    : 1.0 - initial release
// ============================================================================
module game_round_controller
  import crossy_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_SECONDS  = 60,
  parameter int unsigned COUNTDOWN_SEC  = 3,
  parameter int unsigned WIN_SCORE      = 5,
  parameter logic [7:0]  START_KEY      = KEY_SPACE,
  parameter logic [7:0]  PAUSE_KEY      = KEY_P
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic [7:0] keycode,
  input  logic       p1_score_evt,
  input  logic       p2_score_evt,
  output logic [2:0] state,
  output logic       frame_tick,
  output logic       player_reset,
  output logic       player_enable,
  output logic [3:0] timer_tens,
  output logic [3:0] timer_ones,
  output logic [3:0] countdown,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner
);

  localparam logic [3:0] WIN_Q       = 4'(WIN_SCORE);
  localparam logic [3:0] COUNTDOWN_Q = 4'(COUNTDOWN_SEC);
  localparam logic [7:0] ROUND_BCD   = to_bcd(ROUND_SECONDS);

  game_state_t state_q, state_d;
  winner_t     winner_q, winner_d;
  logic [7:0]  prev_key_q;
  logic [3:0]  countdown_q, countdown_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  p1_q, p1_d;
  logic [3:0]  p2_q, p2_d;

  logic        sec_tick;
  logic        tick_clear;
  logic        tick_run;
  logic        start_edge;
  logic        pause_edge;
  logic [3:0]  dec_tens;
  logic [3:0]  dec_ones;
  logic        p1_win;
  logic        p2_win;

  // --------------------------------------------------------------------------
  // Frame / second timebase
  // --------------------------------------------------------------------------
  assign tick_run   = (state_q == ST_COUNTDOWN) || (state_q == ST_PLAY);
  assign tick_clear = (state_d != state_q);

  frame_tick_gen #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_frame_tick_gen (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .vs        (vs),
    .clear     (tick_clear),
    .run       (tick_run),
    .frame_tick(frame_tick),
    .sec_tick  (sec_tick)
  );

  // Key presses act only on the first cycle a code appears; holding a key
  // never retriggers.
  assign start_edge = (keycode == START_KEY) && (prev_key_q != START_KEY);
  assign pause_edge = (keycode == PAUSE_KEY) && (prev_key_q != PAUSE_KEY);

  // One-second BCD decrement with borrow from tens.
  always_comb begin
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end else begin
      dec_ones = ones_q - 4'd1;
      dec_tens = tens_q;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    countdown_d = countdown_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p1_win      = 1'b0;
    p2_win      = 1'b0;

    unique case (state_q)
      ST_TITLE: begin
        if (start_edge) begin
          state_d     = ST_COUNTDOWN;
          countdown_d = COUNTDOWN_Q;
          p1_d        = 4'd0;
          p2_d        = 4'd0;
          winner_d    = WIN_NONE;
        end
      end

      ST_COUNTDOWN: begin
        if (sec_tick) begin
          if (countdown_q == 4'd1) begin
            state_d     = ST_PLAY;
            countdown_d = 4'd0;
            tens_d      = ROUND_BCD[7:4];
            ones_d      = ROUND_BCD[3:0];
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end
      end

      ST_PLAY: begin
        // Scores are below WIN_SCORE while playing, so saturation only has
        // to stop the increment at the limit.
        if (p1_score_evt && (p1_q != WIN_Q)) p1_d = p1_q + 4'd1;
        if (p2_score_evt && (p2_q != WIN_Q)) p2_d = p2_q + 4'd1;
        if (sec_tick) begin
          tens_d = dec_tens;
          ones_d = dec_ones;
        end
        p1_win = (p1_d == WIN_Q);
        p2_win = (p2_d == WIN_Q);

        // Score win beats timer expiry beats pause.
        if (p1_win || p2_win) begin
          state_d  = ST_GAME_OVER;
          winner_d = winner_t'({p2_win, p1_win});
        end else if (sec_tick && (dec_tens == 4'd0) && (dec_ones == 4'd0)) begin
          state_d = ST_GAME_OVER;
          if (p1_d > p2_d)      winner_d = WIN_P1;
          else if (p2_d > p1_d) winner_d = WIN_P2;
          else                  winner_d = WIN_TIE;
        end else if (pause_edge) begin
          state_d = ST_PAUSED;
        end
      end

      ST_PAUSED: begin
        if (pause_edge)      state_d = ST_PLAY;
        else if (start_edge) state_d = ST_TITLE;
      end

      ST_GAME_OVER: begin
        if (start_edge) state_d = ST_TITLE;
      end

      default: begin
        state_d = ST_TITLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_TITLE;
      winner_q    <= WIN_NONE;
      prev_key_q  <= 8'h00;
      countdown_q <= 4'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      p1_q        <= 4'd0;
      p2_q        <= 4'd0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      prev_key_q  <= keycode;
      countdown_q <= countdown_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign state         = state_q;
  assign player_reset  = (state_q == ST_TITLE) || (state_q == ST_COUNTDOWN);
  assign player_enable = (state_q == ST_PLAY);
  assign timer_tens    = tens_q;
  assign timer_ones    = ones_q;
  assign countdown     = countdown_q;
  assign p1_score      = p1_q;
  assign p2_score      = p2_q;
  assign winner        = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_game_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_round_controller
// Description : Self-checking bench for game_round_controller. A behavioural
//               game model (integer seconds, plain score arithmetic) is
//               compared against every DUT output each cycle; directed
//               scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_round_controller;

  localparam int FPS   = 4;
  localparam int ROUND = 12;
  localparam int CDSEC = 3;
  localparam int WIN   = 3;

  localparam int S_TITLE = 0;
  localparam int S_CD    = 1;
  localparam int S_PLAY  = 2;
  localparam int S_PAUSE = 3;
  localparam int S_OVER  = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       vs = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       p1_score_evt = 1'b0;
  logic       p2_score_evt = 1'b0;
  logic [2:0] state;
  logic       frame_tick;
  logic       player_reset;
  logic       player_enable;
  logic [3:0] timer_tens;
  logic [3:0] timer_ones;
  logic [3:0] countdown;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  game_round_controller #(
    .FRAMES_PER_SEC(FPS),
    .ROUND_SECONDS (ROUND),
    .COUNTDOWN_SEC (CDSEC),
    .WIN_SCORE     (WIN)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .vs           (vs),
    .keycode      (keycode),
    .p1_score_evt (p1_score_evt),
    .p2_score_evt (p2_score_evt),
    .state        (state),
    .frame_tick   (frame_tick),
    .player_reset (player_reset),
    .player_enable(player_enable),
    .timer_tens   (timer_tens),
    .timer_ones   (timer_ones),
    .countdown    (countdown),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .winner       (winner)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int   m_state = S_TITLE;
  int   m_cd = 0;
  int   m_timer = 0;
  int   m_s1 = 0;
  int   m_s2 = 0;
  int   m_win = 0;
  int   m_frames = 0;
  int   m_nxt;
  logic [7:0] m_prev_key = 8'h00;
  bit   m_ft = 1'b0;
  bit   h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;
  bit   m_sec, m_st, m_pz;

  initial begin
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        m_state = S_TITLE; m_cd = 0; m_timer = 0; m_s1 = 0; m_s2 = 0;
        m_win = 0; m_frames = 0; m_prev_key = 8'h00; m_ft = 1'b0;
        h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
      end else begin
        // Seconds: every FPS-th frame spent counting down or playing.
        m_sec = 1'b0;
        if (m_ft && (m_state == S_CD || m_state == S_PLAY)) begin
          m_frames++;
          if (m_frames == FPS) begin
            m_sec = 1'b1;
            m_frames = 0;
          end
        end
        m_st = (keycode == 8'h2C) && (m_prev_key != 8'h2C);
        m_pz = (keycode == 8'h13) && (m_prev_key != 8'h13);
        m_prev_key = keycode;
        m_nxt = m_state;
        case (m_state)
          S_TITLE: if (m_st) begin
            m_nxt = S_CD; m_cd = CDSEC; m_s1 = 0; m_s2 = 0; m_win = 0;
          end
          S_CD: if (m_sec) begin
            if (m_cd == 1) begin
              m_nxt = S_PLAY; m_cd = 0; m_timer = ROUND;
            end else begin
              m_cd--;
            end
          end
          S_PLAY: begin
            m_s1 = (m_s1 + p1_score_evt > WIN) ? WIN : m_s1 + p1_score_evt;
            m_s2 = (m_s2 + p2_score_evt > WIN) ? WIN : m_s2 + p2_score_evt;
            if (m_sec) m_timer--;
            if (m_s1 == WIN || m_s2 == WIN) begin
              m_nxt = S_OVER;
              m_win = (m_s1 == WIN ? 1 : 0) + (m_s2 == WIN ? 2 : 0);
            end else if (m_timer == 0) begin
              m_nxt = S_OVER;
              m_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
            end else if (m_pz) begin
              m_nxt = S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (m_pz)      m_nxt = S_PLAY;
            else if (m_st) m_nxt = S_TITLE;
          end
          default: if (m_st) m_nxt = S_TITLE;
        endcase
        if (m_nxt != m_state) m_frames = 0;
        m_state = m_nxt;
        // A frame is seen three clocks after the pin rises.
        m_ft = h2 && !h3;
        h3 = h2; h2 = h1; h1 = vs;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge Clk);
      #2;
      if (cmp_en) begin
        chk("state",      int'(state),         m_state);
        chk("frame_tick", int'(frame_tick),    int'(m_ft));
        chk("p_reset",    int'(player_reset),  (m_state == S_TITLE || m_state == S_CD) ? 1 : 0);
        chk("p_enable",   int'(player_enable), (m_state == S_PLAY) ? 1 : 0);
        chk("tens",       int'(timer_tens),    m_timer / 10);
        chk("ones",       int'(timer_ones),    m_timer % 10);
        chk("countdown",  int'(countdown),     m_cd);
        chk("p1_score",   int'(p1_score),      m_s1);
        chk("p2_score",   int'(p2_score),      m_s2);
        chk("winner",     int'(winner),        m_win);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  // One vsync pulse; optional score events land in the cycle the frame
  // (and any second tick) is visible.
  task automatic frame(input logic e1, input logic e2);
    @(negedge Clk) vs = 1'b0;
    repeat (3) @(negedge Clk);
    vs = 1'b1;
    repeat (3) @(negedge Clk);
    p1_score_evt = e1;
    p2_score_evt = e2;
    @(negedge Clk);
    p1_score_evt = 1'b0;
    p2_score_evt = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic evt(input logic e1, input logic e2);
    @(negedge Clk);
    p1_score_evt = e1;
    p2_score_evt = e2;
    @(negedge Clk);
    p1_score_evt = 1'b0;
    p2_score_evt = 1'b0;
    @(negedge Clk);
  endtask

  task automatic key(input logic [7:0] k);
    @(negedge Clk) keycode = k;
    repeat (2) @(negedge Clk);
  endtask

  // From GAME_OVER or PAUSED: abort to title, start, run the countdown.
  task automatic new_round();
    key(8'h00); key(8'h2C); key(8'h00); key(8'h2C); key(8'h00);
    repeat (12) frame(1'b0, 1'b0);
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge Clk);
    cmp_en = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_preset", int'(player_reset), 1);
    chk("rst_enable", int'(player_enable), 0);
    chk("rst_timer", int'({timer_tens, timer_ones}), 0);
    #1 Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Start key held across the whole countdown: a single transition.
    key(8'h2C);
    chk("t1_state", int'(state), S_CD);
    chk("t1_cd", int'(countdown), 3);
    repeat (12) frame(1'b0, 1'b0);
    chk("t2_state", int'(state), S_PLAY);
    chk("t2_timer12", int'({timer_tens, timer_ones}), 8'h12);
    repeat (4) frame(1'b0, 1'b0);
    chk("t2_timer11", int'({timer_tens, timer_ones}), 8'h11);
    repeat (8) frame(1'b0, 1'b0);
    chk("t2_timer09", int'({timer_tens, timer_ones}), 8'h09);

    // Player 1 reaches the win score.
    key(8'h00);
    evt(1'b1, 1'b0); evt(1'b1, 1'b0); evt(1'b1, 1'b0);
    chk("t3_p1", int'(p1_score), 3);
    chk("t3_state", int'(state), S_OVER);
    chk("t3_winner", int'(winner), 1);
    chk("t3_enable", int'(player_enable), 0);
    repeat (6) frame(1'b0, 1'b0);
    chk("t3_timer_frozen", int'({timer_tens, timer_ones}), 8'h09);

    // Both players reach the win score in the same cycle.
    new_round();
    chk("t4_p1_clr", int'(p1_score), 0);
    evt(1'b1, 1'b0); evt(1'b1, 1'b0); evt(1'b0, 1'b1); evt(1'b0, 1'b1);
    chk("t4_state_play", int'(state), S_PLAY);
    evt(1'b1, 1'b1);
    chk("t4_state", int'(state), S_OVER);
    chk("t4_winner", int'(winner), 3);
    chk("t4_p2", int'(p2_score), 3);

    // Winning event coincides with the timer reaching 00.
    new_round();
    evt(1'b1, 1'b0); evt(1'b1, 1'b0);
    repeat (47) frame(1'b0, 1'b0);
    chk("t4b_timer01", int'({timer_tens, timer_ones}), 8'h01);
    frame(1'b1, 1'b0);
    chk("t4b_timer00", int'({timer_tens, timer_ones}), 8'h00);
    chk("t4b_state", int'(state), S_OVER);
    chk("t4b_winner", int'(winner), 1);
    chk("t4b_p1", int'(p1_score), 3);

    // Timer expiry with player 2 ahead.
    new_round();
    evt(1'b0, 1'b1);
    repeat (48) frame(1'b0, 1'b0);
    chk("tx_state", int'(state), S_OVER);
    chk("tx_winner", int'(winner), 2);

    // Pause, ignore events, resume, abort from pause.
    new_round();
    repeat (4) frame(1'b0, 1'b0);
    key(8'h13);
    chk("t5_state", int'(state), S_PAUSE);
    chk("t5_enable", int'(player_enable), 0);
    repeat (40) frame(1'b1, 1'b1);
    chk("t5_timer", int'({timer_tens, timer_ones}), 8'h11);
    chk("t5_p1", int'(p1_score), 0);
    key(8'h00); key(8'h13);
    chk("t5_resume", int'(state), S_PLAY);
    key(8'h00); key(8'h13); key(8'h00); key(8'h2C);
    chk("t5_abort", int'(state), S_TITLE);

    // Asynchronous reset in the middle of a round.
    key(8'h00); key(8'h2C); key(8'h00);
    repeat (12) frame(1'b0, 1'b0);
    evt(1'b1, 1'b0);
    repeat (20) frame(1'b0, 1'b0);
    chk("t6_timer07", int'({timer_tens, timer_ones}), 8'h07);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    chk("t6_state", int'(state), S_TITLE);
    chk("t6_p1", int'(p1_score), 0);
    chk("t6_timer", int'({timer_tens, timer_ones}), 0);
    chk("t6_preset", int'(player_reset), 1);
    @(negedge Clk);
    #1 Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
